dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side end of the per-thread LSU load/store handshake.
- Serves NUM_CONSUMERS compute-unit LSUs from one shared on-chip Q1.15 data array: arbitrates requests, performs the single-port access, returns ready (and data for reads).
- Sits between the core's compute units and the data memory, in place of the external data-memory model.

Parameters:
- NUM_CONSUMERS, 4, number of LSU lanes (one per thread).
- ADDR_BITS, 12, address width per lane.
- DATA_BITS, 16, word width (Q1.15).
- MEM_DEPTH, 256, words implemented; addresses >= MEM_DEPTH are out of range.
- READ_LATENCY, 1, array read cycles (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-lane read request, held until ready.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  lane i at [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  one-cycle read acknowledge.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  read data, valid while ready is high.
- consumer_write_valid  in  NUM_CONSUMERS  per-lane write request, held until ready.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write address.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data.
- consumer_write_ready  out  NUM_CONSUMERS  one-cycle write acknowledge.

Behaviour:
- Reset (reset low, asynchronous):
  - All ready bits 0; all read_data 0.
  - FSM goes to IDLE; round-robin pointer 0; all done flags 0.
  - Array contents are not reset.
- Requesters: 2*NUM_CONSUMERS slots. Reads of lanes 0..N-1 are slots 0..N-1; writes of lanes 0..N-1 are slots N..2N-1.
- Eligibility: a slot is eligible when its valid is high and its done flag is clear.
- FSM states IDLE, READ_WAIT, RESPOND.
- IDLE, no eligible slot: stay in IDLE.
- IDLE, eligible slot present:
  - Grant the first eligible slot at or after the pointer, wrapping.
  - Latch slot index, address and write data.
  - Pointer becomes (granted+1) mod 2N.
  - Read grant -> READ_WAIT.
  - Write grant: array updated at this edge -> RESPOND.
- READ_WAIT: counter loaded with READ_LATENCY-1 and decrements; at 0, latch array word -> RESPOND.
- RESPOND:
  - Granted lane's ready is 1 for exactly this cycle; for reads, data is driven on that lane's read_data slice and held until the next grant to that lane.
  - Set that slot's done flag -> IDLE.
- Latency: valid sampled in IDLE at cycle 0 -> write ready in cycle 1; read ready in cycle 1+READ_LATENCY.
- Done flag clears the cycle after its valid is observed low. No re-grant of the same held request.
- Same lane asserts read and write together: both are queued as separate slots; read slot index is lower.
- Out-of-range address: read returns 0, write discarded; both are still acknowledged with normal latency.
- Valid dropped before ready (protocol violation): the transaction still completes; a write still commits.
- At most one ready bit is high in any cycle.
- Single outstanding access at a time; no pipelining across grants.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state enum (IDLE, READ_WAIT, RESPOND).
  - Slot-index width function $clog2(2*NUM_CONSUMERS).
  - Localparam for the out-of-range read value (0).
- Sub-module rr_arbiter, 2N-wide request vector in:
  - Outputs: grant index, grant_valid.
  - Pointer advanced on accept pulse.
  - Reusable by the program-memory fetch path.

Test Plan:
- Write then read: lane 0 writes 0x4000 to addr 5 -> write_ready[0] pulses in cycle 1. Lane 0 then reads addr 5 -> read_ready[0] in cycle 2 (READ_LATENCY=1) with read_data[0]=0x4000.
- All four lanes read simultaneously (addrs 0..3 preloaded with 0x1111..0x4444) -> acknowledged in order lane 0,1,2,3. Each ready is a single-cycle pulse with the matching data, and no two ready bits are ever high together.
- Fairness: lane 1 keeps re-requesting writes while lane 2 has a read pending -> lane 2 is granted no later than the second arbitration after lane 1's first grant. Pointer wraps from slot 7 to 0.
- Held valid: lane 3 keeps read_valid high for 10 cycles after ready -> exactly one ready pulse. A new request after one low cycle is served again.
- Out of range: read addr 300 -> ready with data 0x0000. Write 0x7FFF to addr 300 -> ready, and array addr 44 is unchanged.
- Reset mid-read: assert reset in READ_WAIT -> ready/data go 0 immediately. After release, lane requests are re-granted starting from slot 0, and previously written data is intact.

Source files
------------

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder and its arbiter.
//   dmem_state_e    : responder FSM state encoding
//   slot_bits()     : index width for the 2*N read/write requester slots
//   OOR_READ_VALUE  : word returned for reads beyond the implemented array
// ----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      RESPOND   = 2'd2
   } dmem_state_e;

   // Each lane owns a read slot and a write slot, so the arbiter sees 2*N.
   function automatic int slot_bits(input int num_consumers);
      return (num_consumers < 1) ? 1 : $clog2(2 * num_consumers);
   endfunction

   localparam int OOR_READ_VALUE = 0;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin pick over a request vector. The winner is the first set request
// at or after the pointer, wrapping. The pointer moves to (winner+1) mod
// NUM_REQ only when the consumer pulses i_accept, so a look-ahead grant that
// is not taken leaves the rotation untouched.
//   clk, rst_n     : clock, async active-low reset (pointer -> 0)
//   i_req          : NUM_REQ request bits
//   i_accept       : consumer takes the current grant this cycle
//   o_grant_idx    : index of the winning request
//   o_grant_valid  : at least one request is set
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ  = 8,
   parameter int IDX_BITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  i_req,
   input  logic                i_accept,
   output logic [IDX_BITS-1:0] o_grant_idx,
   output logic                o_grant_valid
);

   logic [IDX_BITS-1:0] r_ptr;
   logic [IDX_BITS-1:0] w_idx;
   logic                w_found;

   // Scan from the farthest slot back toward the pointer so the last hit
   // written is the nearest one at/after the pointer; no early exit needed.
   always_comb begin : find_winner
      int s;
      s       = 0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         s = (int'(r_ptr) + i) % NUM_REQ;
         if (i_req[IDX_BITS'(s)]) begin
            w_idx   = IDX_BITS'(s);
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_accept && w_found) begin
         r_ptr <= IDX_BITS'((int'(w_idx) + 1) % NUM_REQ);
      end
   end

   assign o_grant_idx   = w_idx;
   assign o_grant_valid = w_found;

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the per-thread LSU load/store handshake. Serves
// NUM_CONSUMERS lanes from one single-port Q1.15 array, one access at a time.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | arbitrate; a write commits on the grant edge
// READ_WAIT | array read in flight, counter runs READ_LATENCY-1 .. 0
// RESPOND   | one-cycle ready on the granted lane, done flag set
//
// Ports
//   clk, reset                : clock, async active-low reset
//   consumer_read_valid/addr  : per-lane read request, held until ready
//   consumer_read_ready/data  : one-cycle acknowledge, data held per lane
//   consumer_write_valid/addr/data : per-lane write request
//   consumer_write_ready      : one-cycle write acknowledge
//
// Slot numbering: reads of lanes 0..N-1 are slots 0..N-1, writes are N..2N-1,
// so a lane issuing both at once has its read served first from pointer 0.
// A done flag per slot blocks re-granting a request that is still held; it
// clears once the valid has been seen low at a clock edge.
// ----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 12,
   parameter int DATA_BITS     = 16,
   parameter int MEM_DEPTH     = 256,
   parameter int READ_LATENCY  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready
);

   localparam int NUM_SLOTS    = 2 * NUM_CONSUMERS;
   localparam int SLOT_BITS    = slot_bits(NUM_CONSUMERS);
   localparam int LANE_BITS    = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam int CNT_BITS     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int MEM_IDX_BITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   dmem_state_e r_state;
   dmem_state_e w_next_state;

   logic [SLOT_BITS-1:0]               r_slot;
   logic [ADDR_BITS-1:0]               r_addr;
   logic [CNT_BITS-1:0]                r_cnt;
   logic [NUM_SLOTS-1:0]               r_done;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] r_rd_data;
   logic [DATA_BITS-1:0]               r_mem [MEM_DEPTH];

   logic [NUM_SLOTS-1:0] w_slot_valid;
   logic [NUM_SLOTS-1:0] w_eligible;
   logic [NUM_SLOTS-1:0] w_set_done;
   logic [NUM_SLOTS-1:0] w_done_next;
   logic [SLOT_BITS-1:0] w_grant_idx;
   logic                 w_grant_valid;
   logic                 w_accept;
   logic                 w_grant_is_wr;
   logic [LANE_BITS-1:0] w_grant_lane;
   logic [ADDR_BITS-1:0] w_grant_addr;
   logic [DATA_BITS-1:0] w_grant_wdata;
   logic                 w_grant_in_range;
   logic                 w_cur_is_wr;
   logic [LANE_BITS-1:0] w_cur_lane;
   logic                 w_cur_in_range;
   logic [DATA_BITS-1:0] w_rd_word;

   assign w_slot_valid = {consumer_write_valid, consumer_read_valid};
   assign w_eligible   = w_slot_valid & ~r_done;
   assign w_accept     = (r_state == IDLE) && w_grant_valid;

   rr_arbiter #(
      .NUM_REQ  (NUM_SLOTS),
      .IDX_BITS (SLOT_BITS)
   ) u_arb (
      .clk           (clk),
      .rst_n         (reset),
      .i_req         (w_eligible),
      .i_accept      (w_accept),
      .o_grant_idx   (w_grant_idx),
      .o_grant_valid (w_grant_valid)
   );

   // Decode the candidate grant into lane / direction / address.
   always_comb begin
      w_grant_is_wr = (int'(w_grant_idx) >= NUM_CONSUMERS);
      w_grant_lane  = w_grant_is_wr ? LANE_BITS'(int'(w_grant_idx) - NUM_CONSUMERS)
                                    : LANE_BITS'(int'(w_grant_idx));
      w_grant_addr  = w_grant_is_wr
                    ? consumer_write_address[int'(w_grant_lane)*ADDR_BITS +: ADDR_BITS]
                    : consumer_read_address[int'(w_grant_lane)*ADDR_BITS +: ADDR_BITS];
      w_grant_wdata = consumer_write_data[int'(w_grant_lane)*DATA_BITS +: DATA_BITS];
      w_grant_in_range = (32'(w_grant_addr) < 32'(MEM_DEPTH));
   end

   // Decode the transaction currently being served.
   always_comb begin
      w_cur_is_wr    = (int'(r_slot) >= NUM_CONSUMERS);
      w_cur_lane     = w_cur_is_wr ? LANE_BITS'(int'(r_slot) - NUM_CONSUMERS)
                                   : LANE_BITS'(int'(r_slot));
      w_cur_in_range = (32'(r_addr) < 32'(MEM_DEPTH));
      w_rd_word      = w_cur_in_range ? r_mem[r_addr[MEM_IDX_BITS-1:0]]
                                      : DATA_BITS'(OOR_READ_VALUE);
   end

   always_comb begin
      w_set_done = '0;
      if (r_state == RESPOND) begin
         w_set_done[r_slot] = 1'b1;
      end
      w_done_next = (r_done & w_slot_valid) | w_set_done;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) begin
               w_next_state = w_grant_is_wr ? RESPOND : READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (r_cnt == '0) begin
               w_next_state = RESPOND;
            end
         end
         RESPOND: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      consumer_read_ready  = '0;
      consumer_write_ready = '0;
      if (r_state == RESPOND) begin
         if (w_cur_is_wr) begin
            consumer_write_ready[w_cur_lane] = 1'b1;
         end else begin
            consumer_read_ready[w_cur_lane] = 1'b1;
         end
      end
   end

   assign consumer_read_data = r_rd_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot    <= '0;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_done    <= '0;
         r_rd_data <= '0;
      end else begin
         r_done <= w_done_next;
         if (w_accept) begin
            r_slot <= w_grant_idx;
            r_addr <= w_grant_addr;
            r_cnt  <= CNT_BITS'(READ_LATENCY - 1);
         end else if (r_state == READ_WAIT) begin
            if (r_cnt == '0) begin
               r_rd_data[int'(w_cur_lane)*DATA_BITS +: DATA_BITS] <= w_rd_word;
            end else begin
               r_cnt <= r_cnt - CNT_BITS'(1);
            end
         end
      end
   end

   // Array contents survive reset; writes commit on the grant edge itself,
   // so a requester that drops valid early still gets its store.
   always_ff @(posedge clk) begin
      if (w_accept && w_grant_is_wr && w_grant_in_range) begin
         r_mem[w_grant_addr[MEM_IDX_BITS-1:0]] <= w_grant_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int N     = 4;
   localparam int AB    = 12;
   localparam int DB    = 16;
   localparam int DEPTH = 256;
   localparam int RL    = 1;
   localparam int NS    = 2 * N;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    rv, wv, rr, wr;
   logic [N*AB-1:0] ra, wa;
   logic [N*DB-1:0] wd, rd;

   dmem_responder #(
      .NUM_CONSUMERS (N),
      .ADDR_BITS     (AB),
      .DATA_BITS     (DB),
      .MEM_DEPTH     (DEPTH),
      .READ_LATENCY  (RL)
   ) dut (
      .clk                    (clk),
      .reset                  (rst_n),
      .consumer_read_valid    (rv),
      .consumer_read_address  (ra),
      .consumer_read_ready    (rr),
      .consumer_read_data     (rd),
      .consumer_write_valid   (wv),
      .consumer_write_address (wa),
      .consumer_write_data    (wd),
      .consumer_write_ready   (wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      int          lane;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_vec;
   int          n_err;
   logic [15:0] mdl [DEPTH];
   int          tb_ptr;
   bit          mask [NS];
   int          slot_addr [NS];
   logic [15:0] slot_data [NS];
   int          rereq_left;
   int          pend;
   int          fr_addr;
   logic [15:0] fr_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic slot_req(input int s, input int addr, input logic [15:0] data);
      int l;
      l            = s % N;
      mask[s]      = 1'b1;
      slot_addr[s] = addr;
      slot_data[s] = data;
      if (s < N) begin
         rv[l +: 1]       = 1'b1;
         ra[l*AB +: AB]   = AB'(addr);
      end else begin
         wv[l +: 1]       = 1'b1;
         wa[l*AB +: AB]   = AB'(addr);
         wd[l*DB +: DB]   = data;
      end
   endtask

   // Reference round-robin: order pending slots from tb_ptr, compute the
   // expected ready cycle (grant edge 0 = first edge after issue) and the
   // expected read data from the shadow array.
   task automatic predict();
      int   g;
      int   s;
      int   a;
      exp_t e;
      g = 0;
      for (int n = 0; n < NS; n++) begin
         s = -1;
         for (int i = NS - 1; i >= 0; i--) begin
            if (mask[(tb_ptr + i) % NS]) s = (tb_ptr + i) % NS;
         end
         if (s >= 0) begin
            a       = slot_addr[s];
            e.is_wr = (s >= N);
            e.lane  = s % N;
            e.data  = (!e.is_wr && a < DEPTH) ? mdl[a] : 16'h0000;
            e.cyc   = g + 1 + (e.is_wr ? 0 : RL);
            if (e.is_wr && a < DEPTH) mdl[a] = slot_data[s];
            sb.push_back(e);
            mask[s] = 1'b0;
            tb_ptr  = (s + 1) % NS;
            g       = e.cyc + 1;
         end
      end
   endtask

   task automatic run(input int max_cyc, input bit drop, input bit stop_empty);
      int           k;
      int           lane;
      bit           is_wr;
      exp_t         e;
      logic [N-1:0] rdy;
      k = 0;
      while (k < max_cyc && !(stop_empty && sb.size() == 0 && rereq_left == 0 && pend == 0)) begin
         @(negedge clk);
         k++;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               wv[1 +: 1]   = 1'b1;
               wa[AB +: AB] = AB'(fr_addr);
               wd[DB +: DB] = fr_data;
               fr_addr++;
               fr_data++;
               rereq_left--;
            end
         end
         rdy = rr | wr;
         if (rdy != '0) begin
            is_wr = (wr != '0);
            lane  = 0;
            for (int i = 0; i < N; i++) if (rdy[i +: 1] == 1'b1) lane = i;
            chk("one_ready", $countones({wr, rr}), 1);
            if (sb.size() == 0) begin
               chk("extra_ready", {24'h0, wr, rr}, 0);
            end else begin
               e = sb.pop_front();
               chk("lane", lane, e.lane);
               chk("kind", {31'h0, is_wr}, {31'h0, e.is_wr});
               if (!is_wr) chk("rdata", {16'h0, rd[lane*DB +: DB]}, {16'h0, e.data});
               if (e.cyc >= 0) chk("latency", k, e.cyc);
            end
            if (drop) begin
               if (is_wr) wv[lane +: 1] = 1'b0;
               else       rv[lane +: 1] = 1'b0;
               if (is_wr && lane == 1 && rereq_left > 0) pend = 2;
            end
         end
      end
      if (stop_empty && sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic go();
      predict();
      run(300, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      n_vec = 0; n_err = 0; tb_ptr = 0;
      rereq_left = 0; pend = 0; fr_addr = 0; fr_data = '0;
      for (int i = 0; i < NS; i++) begin mask[i] = 1'b0; slot_addr[i] = 0; slot_data[i] = '0; end
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_rready", {28'h0, rr}, 0);
      chk("rst_wready", {28'h0, wr}, 0);
      chk("rst_rdata_lo", rd[31:0], 0);
      chk("rst_rdata_hi", rd[63:32], 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // write then read back, lane 0
      slot_req(4, 5, 16'h4000); go();
      slot_req(0, 5, 16'h0000); go();

      // preload 0..3 from all lanes (wraps 7 -> 0), then four concurrent reads
      for (int l = 0; l < N; l++) slot_req(N + l, l, 16'(16'h1111 * (l + 1)));
      go();
      for (int l = 0; l < N; l++) slot_req(l, l, 16'h0000);
      go();

      // fairness: lane 1 keeps re-requesting writes while lane 2 read waits
      slot_req(5, 10, 16'h0A0A);
      slot_req(2, 1, 16'h0000);
      predict();
      e.is_wr = 1'b1; e.lane = 1; e.data = '0; e.cyc = -1;
      sb.push_back(e); sb.push_back(e);
      mdl[11] = 16'h0B0B; mdl[12] = 16'h0B0C;
      tb_ptr = 6;
      fr_addr = 11; fr_data = 16'h0B0B; rereq_left = 2;
      run(300, 1'b1, 1'b1);
      repeat (2) @(negedge clk);

      // pointer wrap with mixed reads and a write
      slot_req(7, 20, 16'h1357);
      slot_req(0, 0, 16'h0000);
      slot_req(1, 10, 16'h0000);
      go();

      // held valid: exactly one ready, then served again after one low cycle
      slot_req(3, 2, 16'h0000);
      predict();
      run(13, 1'b0, 1'b0);
      chk("held_pending", sb.size(), 0);
      rv[3] = 1'b0;
      @(negedge clk);
      slot_req(3, 12, 16'h0000); go();

      // out-of-range read returns 0, out-of-range write is dropped
      slot_req(6, 44, 16'hABCD);  go();
      slot_req(6, 300, 16'h7FFF); go();
      slot_req(2, 44, 16'h0000);  go();
      slot_req(2, 300, 16'h0000); go();

      // reset while a read is in flight
      slot_req(1, 44, 16'h0000);
      mask[1] = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_rready", {28'h0, rr}, 0);
      chk("midrst_wready", {28'h0, wr}, 0);
      chk("midrst_rdata_lo", rd[31:0], 0);
      chk("midrst_rdata_hi", rd[63:32], 0);
      rv = '0; wv = '0;
      tb_ptr = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      slot_req(7, 50, 16'h2468);
      slot_req(0, 5, 16'h0000);
      slot_req(1, 20, 16'h0000);
      go();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
